// File: rtl/mem_arbiter_if.sv
// Cache-miss side and RAM side of the shared memory arbiter, bundled as one interface.
// The arbiter uses the slave view; caches and the RAM model together use the master view.
interface mem_arbiter_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]      iREN;
    logic [32*CPUS-1:0]   iaddr;
    logic [CPUS-1:0]      iwait;
    logic [31:0]          iload;
    logic [CPUS-1:0]      dREN;
    logic [CPUS-1:0]      dWEN;
    logic [32*CPUS-1:0]   daddr;
    logic [32*CPUS-1:0]   dstore;
    logic [CPUS-1:0]      dwait;
    logic [31:0]          dload;
    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic                 ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between per-core icache/dcache miss ports: data before instruction,
// round-robin within each class, one registered grant held until ramready or an abort.
module mem_arbiter #(
    parameter int CPUS = 2,
    parameter int RRW  = 1
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [RRW-1:0]  rr;
    logic [RRW-1:0]  gid;
    logic            gtype_d;

    logic [CPUS-1:0] d_req;
    logic            any_d;
    logic [CPUS-1:0] pick_mask;
    logic            pick_found;
    logic [RRW-1:0]  pick_id;
    logic [RRW-1:0]  next_rr;
    logic            g_req;

    logic            ren;
    logic            wen;
    logic [31:0]     addr;
    logic [31:0]     store;
    logic [CPUS-1:0] iwait;
    logic [CPUS-1:0] dwait;

    assign d_req     = bus.dREN | bus.dWEN;
    assign any_d     = |d_req;
    assign pick_mask = any_d ? d_req : bus.iREN;
    assign next_rr   = (gid == RRW'(CPUS - 1)) ? '0 : gid + 1'b1;
    assign g_req     = gtype_d ? d_req[gid] : bus.iREN[gid];

    // First requester of the winning class, scanning upward from rr with wrap.
    always_comb begin : rr_scan
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int k = 0; k < CPUS; k++) begin
            idx = (int'(rr) + k) % CPUS;
            if (!pick_found && pick_mask[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx[RRW-1:0];
            end
        end
    end

    // The RAM port follows the granted core's live inputs so an abort drops the strobe at once.
    always_comb begin : ram_drive
        ren   = 1'b0;
        wen   = 1'b0;
        addr  = '0;
        store = '0;
        iwait = '1;
        dwait = '1;
        if (state == BUSY) begin
            if (gtype_d) begin
                addr = bus.daddr[32*gid +: 32];
                if (bus.dWEN[gid]) begin
                    wen   = 1'b1;
                    store = bus.dstore[32*gid +: 32];
                end else begin
                    ren = 1'b1;
                end
                if (bus.ramready) dwait[gid] = 1'b0;
            end else begin
                ren  = 1'b1;
                addr = bus.iaddr[32*gid +: 32];
                if (bus.ramready) iwait[gid] = 1'b0;
            end
        end
    end

    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = addr;
    assign bus.ramstore = store;
    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            rr      <= '0;
            gid     <= '0;
            gtype_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gid     <= pick_id;
                        gtype_d <= any_d;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion wins over a simultaneous request drop.
                    if (bus.ramready) begin
                        state <= IDLE;
                        rr    <= next_rr;
                    end else if (!g_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run, all
// compared cycle by cycle against a transaction-level model of the grant rules.
module tb_mem_arbiter;
    localparam int CPUS = 2;
    localparam int RRW  = 1;
    localparam logic [CPUS-1:0] ALL1 = '1;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.CPUS(CPUS)) bus ();

    mem_arbiter #(.CPUS(CPUS), .RRW(RRW)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the one outstanding grant (if any) and the round-robin start point.
    bit m_busy = 0;
    int m_core = 0;
    bit m_is_d = 0;
    int m_ptr  = 0;

    logic            obs_ren, obs_wen;
    logic [31:0]     obs_addr, obs_store, obs_iload, obs_dload;
    logic [CPUS-1:0] obs_iwait, obs_dwait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic int pick(input logic [CPUS-1:0] mask, input int ptr);
        for (int k = 0; k < CPUS; k++) begin
            if (mask[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
        end
        return -1;
    endfunction

    // One clock: inputs are already set; compare at negedge, advance model at posedge.
    task automatic cycle();
        logic [CPUS-1:0] e_iwait, e_dwait;
        logic            e_ren, e_wen;
        logic [31:0]     e_addr, e_store;
        int              w;
        @(negedge clk);
        e_iwait = '1; e_dwait = '1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        if (m_busy) begin
            if (m_is_d) begin
                e_addr = bus.daddr[32*m_core +: 32];
                if (bus.dWEN[m_core]) begin
                    e_wen   = 1;
                    e_store = bus.dstore[32*m_core +: 32];
                end else begin
                    e_ren = 1;
                end
                if (bus.ramready) e_dwait[m_core] = 0;
            end else begin
                e_ren  = 1;
                e_addr = bus.iaddr[32*m_core +: 32];
                if (bus.ramready) e_iwait[m_core] = 0;
            end
        end
        obs_ren = bus.ramREN;  obs_wen = bus.ramWEN;
        obs_addr = bus.ramaddr; obs_store = bus.ramstore;
        obs_iwait = bus.iwait; obs_dwait = bus.dwait;
        obs_iload = bus.iload; obs_dload = bus.dload;
        check("ramREN",   obs_ren,   e_ren);
        check("ramWEN",   obs_wen,   e_wen);
        check("ramaddr",  obs_addr,  e_addr);
        check("ramstore", obs_store, e_store);
        check("iwait",    obs_iwait, e_iwait);
        check("dwait",    obs_dwait, e_dwait);
        check("iload",    obs_iload, bus.ramload);
        check("dload",    obs_dload, bus.ramload);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            w = pick(bus.dREN | bus.dWEN, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_core = w; m_is_d = 1;
            end else begin
                w = pick(bus.iREN, m_ptr);
                if (w >= 0) begin
                    m_busy = 1; m_core = w; m_is_d = 0;
                end
            end
        end else if (bus.ramready) begin
            m_busy = 0;
            m_ptr  = (m_core + 1) % CPUS;
        end else if (!(m_is_d ? (bus.dREN[m_core] | bus.dWEN[m_core]) : bus.iREN[m_core])) begin
            m_busy = 0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.ramready = 0;
    endtask

    initial begin
        int              exp_order [5] = '{0, 1, 0, 1, 0};
        logic [CPUS-1:0] ew;
        logic            seen_low;
        bit              i_act [CPUS];
        bit              d_act [CPUS];
        bit              prev_ready;

        clk = 0;
        rst_n = 0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
        clear_inputs();
        @(posedge clk); #1;

        // Reset held two cycles.
        cycle();
        cycle();
        check("rst_ren",   obs_ren,   0);
        check("rst_wen",   obs_wen,   0);
        check("rst_addr",  obs_addr,  0);
        check("rst_store", obs_store, 0);
        check("rst_iwait", obs_iwait, ALL1);
        check("rst_dwait", obs_dwait, ALL1);

        // Single instruction read, ramready three cycles after the grant.
        rst_n = 1;
        bus.iREN[0] = 1; bus.iaddr[31:0] = 32'h0000_0040;
        cycle();
        check("t1_idle_ren", obs_ren, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t1_busy_ren",   obs_ren,   1);
            check("t1_busy_addr",  obs_addr,  32'h40);
            check("t1_busy_iwait", obs_iwait, ALL1);
        end
        bus.ramready = 1; bus.ramload = 32'hDEAD_BEEF;
        cycle();
        check("t1_done_iwait", obs_iwait, 2'b10);
        check("t1_done_iload", obs_iload, 32'hDEAD_BEEF);
        clear_inputs();
        cycle();
        check("t1_back_idle", obs_ren, 0);

        // Data request beats a simultaneous instruction request.
        bus.iREN[0] = 1; bus.iaddr[31:0] = 32'h80;
        bus.dREN[1] = 1; bus.daddr[63:32] = 32'h200;
        cycle();
        bus.ramready = 1;
        cycle();
        check("t2_d_addr",  obs_addr,  32'h200);
        check("t2_d_dwait", obs_dwait, 2'b01);
        check("t2_d_iwait", obs_iwait, ALL1);
        bus.dREN[1] = 0; bus.ramready = 0;
        cycle();
        check("t2_bubble", obs_ren, 0);
        bus.ramready = 1;
        cycle();
        check("t2_i_addr",  obs_addr,  32'h80);
        check("t2_i_iwait", obs_iwait, 2'b10);
        clear_inputs();
        cycle();

        // Round-robin between two continuous writers from rr=0.
        rst_n = 0;
        cycle();
        rst_n = 1;
        bus.dWEN = 2'b11;
        bus.daddr  = {32'h200, 32'h100};
        bus.dstore = {32'h22,  32'h11};
        for (int i = 0; i < 10; i++) begin
            bus.ramready = (i % 2 == 1);
            cycle();
            if (i % 2 == 1) begin
                ew = '1; ew[exp_order[i/2]] = 0;
                check("t3_order", obs_dwait, ew);
                check("t3_store", obs_store, exp_order[i/2] ? 32'h22 : 32'h11);
                check("t3_addr",  obs_addr,  exp_order[i/2] ? 32'h200 : 32'h100);
                check("t3_wen",   obs_wen,   1);
            end
        end
        clear_inputs();
        cycle();

        // Abort of an instruction grant with rr=1: rr must stay 1.
        bus.iREN[1] = 1; bus.iaddr[63:32] = 32'h300;
        seen_low = 0;
        cycle();
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("t4_busy_addr", obs_addr, 32'h300);
            seen_low |= ~obs_iwait[1];
        end
        bus.iREN[1] = 0;
        cycle();
        seen_low |= ~obs_iwait[1];
        cycle();
        seen_low |= ~obs_iwait[1];
        check("t4_strobe_off", obs_ren, 0);
        check("t4_no_wait",    seen_low, 0);
        bus.iREN = 2'b11; bus.iaddr[31:0] = 32'h400;
        cycle();
        cycle();
        check("t4_rr_kept", obs_addr, 32'h300);
        bus.ramready = 1;
        cycle();
        check("t4_done", obs_iwait, 2'b01);
        clear_inputs();
        cycle();

        // Write precedence, then reset in the middle of the write; rr forced to 1 first.
        bus.dREN[0] = 1;
        cycle();
        bus.ramready = 1;
        cycle();
        clear_inputs();
        cycle();
        bus.dREN[0] = 1; bus.dWEN[0] = 1; bus.dstore[31:0] = 32'h55;
        cycle();
        cycle();
        check("t5_wen",   obs_wen,   1);
        check("t5_ren",   obs_ren,   0);
        check("t5_store", obs_store, 32'h55);
        rst_n = 0;
        cycle();
        rst_n = 1;
        bus.dREN = 2'b11;
        cycle();
        check("t5_rst_ren",   obs_ren,   0);
        check("t5_rst_wen",   obs_wen,   0);
        check("t5_rst_iwait", obs_iwait, ALL1);
        check("t5_rst_dwait", obs_dwait, ALL1);
        cycle();
        check("t5_rr_zero", obs_addr, 32'h100);
        bus.ramready = 1;
        cycle();
        clear_inputs();
        cycle();

        // Randomized traffic with aborts, stray ramready pulses and occasional resets.
        for (int c = 0; c < CPUS; c++) begin i_act[c] = 0; d_act[c] = 0; end
        prev_ready = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CPUS; c++) begin
                if (i_act[c] && (!obs_iwait[c] || $urandom_range(39) == 0)) i_act[c] = 0;
                else if (!i_act[c] && $urandom_range(2) == 0) begin
                    i_act[c] = 1;
                    bus.iaddr[32*c +: 32] = $urandom;
                end
                if (d_act[c] && (!obs_dwait[c] || $urandom_range(39) == 0)) d_act[c] = 0;
                else if (!d_act[c] && $urandom_range(2) == 0) begin
                    int kind;
                    kind = $urandom_range(2);
                    d_act[c] = 1;
                    bus.dREN[c] = (kind != 1);
                    bus.dWEN[c] = (kind != 0);
                    bus.daddr[32*c +: 32]  = $urandom;
                    bus.dstore[32*c +: 32] = $urandom;
                end
                bus.iREN[c] = i_act[c];
                if (!d_act[c]) begin bus.dREN[c] = 0; bus.dWEN[c] = 0; end
            end
            bus.ramready = prev_ready ? 1'b0 : ($urandom_range(3) == 0);
            prev_ready   = bus.ramready;
            bus.ramload  = $urandom;
            rst_n        = ($urandom_range(499) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
